serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing A − B one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation companion to the team's adder datapath: the adder sums, this unit differences. It sits behind a simple start/done handshake so a controller can issue back-to-back subtractions without a wide parallel subtractor.

---
 rtl/arith_defs_pkg.sv | 19 +
 rtl/serial_subtractor_fs.sv | 13 +
 rtl/serial_subtractor.sv | 89 ++++++++
 tb/tb_serial_subtractor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arith_defs_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encodings and a ceil-log2 helper.
package arith_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width needed to hold a count of 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell, purely combinational (zero latency, no flow control).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first: result WIDTH edges after start is accepted, one result per WIDTH+1 cycles.
// start is honoured only in IDLE/DONE; a start seen while busy is dropped, not queued.
module serial_subtractor
  import arith_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int              CW   = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bout;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands at r_sh[0].
  assign r_next = {d, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          bin  <= bout;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff   <= r_next;
            borrow <= bout;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular subtraction; borrow is the unsigned less-than.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return WIDTH'(x - y);
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return x < y;
  endfunction

  // One operation from an idle/done state; glitch >= 0 pulses a stray start during RUN.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input string tag, input int glitch);
    int lat;
    int busy_cnt;
    int extra;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (lat == glitch) begin
        start = 1'b1; a = 8'd50; b = 8'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_lat"}, lat, WIDTH);
    check({tag, "_busycyc"}, busy_cnt, WIDTH);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_diff"}, diff, ref_diff(av, bv));
    check({tag, "_borrow"}, borrow, ref_borrow(av, bv));
    tick();
    check({tag, "_done_fall"}, done, 0);
    if (glitch >= 0) begin
      extra = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) extra++;
        tick();
      end
      check({tag, "_no_second_done"}, extra, 0);
    end
  endtask

  initial begin
    int periods[$];
    int last_done;
    int viol;
    int extra;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    #10 rst = 1'b0;
    tick();

    do_op(8'd10, 8'd3, "basic", -1);
    do_op(8'd3, 8'd10, "neg", -1);
    do_op(8'd0, 8'd1, "zero_minus_one", -1);
    do_op(8'hFF, 8'hFF, "ff_ff", -1);
    do_op(8'd0, 8'd0, "zero_zero", -1);
    do_op(8'h20, 8'h05, "ignored_start", 2);

    // Continuous start: one result every WIDTH+1 cycles, busy low only with done.
    a = 8'd5; b = 8'd2; start = 1'b1;
    tick();
    last_done = -1;
    viol = 0;
    for (int t = 1; t <= 4 * (WIDTH + 1); t++) begin
      if (busy == done) viol++;
      if (done) begin
        check("b2b_diff", diff, 3);
        if (last_done >= 0) periods.push_back(t - last_done);
        last_done = t;
      end
      tick();
    end
    start = 1'b0;
    check("b2b_busy_vs_done", viol, 0);
    check("b2b_nperiods", periods.size(), 3);
    foreach (periods[i]) check("b2b_period", periods[i], WIDTH + 1);
    for (int i = 0; i < 2 * WIDTH; i++) tick();

    // Asynchronous abort mid-operation.
    a = 8'h80; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    tick();
    #2 rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) extra++;
      tick();
    end
    check("abort_quiet", extra, 0);
    do_op(8'h80, 8'h01, "after_abort", -1);

    for (int n = 0; n < 25; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      do_op(ra, rb, "rand", -1);
      for (int i = 0; i < $urandom_range(0, 2); i++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
